// File: rtl/vec_seq_pkg.sv
// ---------------------------------------------------------------------------
// vec_seq_pkg
// Shared definitions for the vector ALU sequencer slice:
//   - VLEN / IDX_W      : vector length and element index width
//   - seq_state_t       : sequencer state encoding
//   - OP_*              : ALU operation codes carried on cmd_op / alu_op
// ---------------------------------------------------------------------------
package vec_seq_pkg;

    localparam int VLEN  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARST   = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_EXEC   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

endpackage

// File: rtl/vec_seq_pipe.sv
// ---------------------------------------------------------------------------
// vec_seq_pipe
// Fixed-latency valid + element-index delay line that models the ALU
// issue-to-result path. An issue presented in cycle t appears on res_valid /
// res_idx in cycle t + DEPTH. There is no stall path.
//
// Ports:
//   clock        in   sole clock
//   flush        in   synchronous clear of every stage (reset or abort)
//   issue_valid  in   element issued to the ALU this cycle
//   issue_idx    in   index of the issued element
//   res_valid    out  result for an earlier issue is available
//   res_idx      out  index of that result
// ---------------------------------------------------------------------------
module vec_seq_pipe
    import vec_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = IDX_W
) (
    input  logic             clock,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [WIDTH-1:0] issue_idx,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_idx
);

    logic [DEPTH-1:0] valid_sr;
    logic [WIDTH-1:0] idx_sr [DEPTH];

    // Shift register: stage 0 captures the new issue, every later stage takes
    // its predecessor. A flush empties the whole line in one edge so that no
    // result of a cancelled command ever reaches the output. Indices of empty
    // slots are kept at zero so res_idx stays quiet when nothing is valid.
    always_ff @(posedge clock) begin
        if (flush) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= issue_valid;
            idx_sr[0]   <= issue_valid ? issue_idx : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                idx_sr[i]   <= idx_sr[i-1];
            end
        end
    end

    assign res_valid = valid_sr[DEPTH-1];
    assign res_idx   = idx_sr[DEPTH-1];

endmodule

// File: rtl/vec_alu_sequencer.sv
// ---------------------------------------------------------------------------
// vec_alu_sequencer
// Sequences one vector ALU command: ALU reset strobe, load of operand A and
// operand B element by element, issue of every element to the ALU, drain of
// the fixed-latency result pipe, then a one-cycle done pulse.
//
// Optional feature: define VEC_SEQ_CYCLE_CNT_EN to build the 32-bit busy-cycle
// counter on cycle_cnt; without it cycle_cnt is tied to zero.
//
// Ports:
//   wb_clk_i        in   sole clock
//   wb_rst_i        in   synchronous active-high reset
//   cmd_valid       in   command offered
//   cmd_ready       out  high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_op [3:0]    in   ALU operation code
//   cmd_len [4:0]   in   element count 0..31 (clamped to VLEN)
//   abort           in   cancel the running command
//   ld_valid        in   operand word available
//   ld_ready        out  sequencer is in a load phase
//   vreg_we         out  write operand word into vector register
//   vreg_sel        out  0 = register A, 1 = register B
//   vreg_idx        out  operand element index
//   alu_issue       out  issue one element to the ALU
//   alu_op [3:0]    out  latched opcode
//   alu_idx         out  issued element index
//   res_we          out  write ALU result
//   res_idx         out  result element index
//   busy            out  high in every state except IDLE
//   done            out  one-cycle completion pulse
//   flag_alu_rst    out  ALU reset strobe (GPIO)
//   flag_operand    out  vreg_sel during loads, else 0 (GPIO)
//   flag_operation  out  latched opcode while busy, else 0 (GPIO)
//   cycle_cnt [31:0] out busy-cycle count
// ---------------------------------------------------------------------------
module vec_alu_sequencer
    import vec_seq_pkg::*;
#(
    parameter int VLEN    = 16,
    parameter int IDX_W   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [4:0]       cmd_len,
    input  logic             abort,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic             vreg_we,
    output logic             vreg_sel,
    output logic [IDX_W-1:0] vreg_idx,
    output logic             alu_issue,
    output logic [3:0]       alu_op,
    output logic [IDX_W-1:0] alu_idx,
    output logic             res_we,
    output logic [IDX_W-1:0] res_idx,
    output logic             busy,
    output logic             done,
    output logic             flag_alu_rst,
    output logic             flag_operand,
    output logic [3:0]       flag_operation,
    output logic [31:0]      cycle_cnt
);

    seq_state_t       state;
    logic [3:0]       op_q;
    logic [4:0]       len_q;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] idx_q;

    logic [4:0]       len_clamped;
    logic             in_load;
    logic             accept;
    logic             abort_now;
    logic             pipe_flush;
    logic             pipe_valid;
    logic [IDX_W-1:0] pipe_idx;

    // Commands longer than the register file are silently truncated.
    assign len_clamped = (cmd_len > 5'(VLEN)) ? 5'(VLEN) : cmd_len;

    assign in_load   = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign accept    = cmd_valid && (state == ST_IDLE);
    // abort is meaningless while idle, so it only counts once busy.
    assign abort_now = abort && (state != ST_IDLE);

    // Main sequencer. Reset and abort both land in IDLE; abort outranks any
    // other transition that happens to coincide with it. idx_q is shared by
    // the load and execute phases because they never overlap: it walks
    // 0..len-1, and is rewound whenever a phase completes. last_idx is the
    // precomputed len-1 so each phase end is a plain equality test.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            len_q    <= '0;
            last_idx <= '0;
            idx_q    <= '0;
        end else if (abort_now) begin
            state <= ST_IDLE;
            idx_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        len_q    <= len_clamped;
                        last_idx <= IDX_W'(len_clamped - 5'd1);
                        idx_q    <= '0;
                        state    <= ST_ARST;
                    end
                end
                ST_ARST: begin
                    idx_q <= '0;
                    state <= (len_q == 5'd0) ? ST_DONE : ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    if (ld_valid) begin
                        if (idx_q == last_idx) begin
                            idx_q <= '0;
                            state <= ST_LOAD_B;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (ld_valid) begin
                        if (idx_q == last_idx) begin
                            idx_q <= '0;
                            state <= ST_EXEC;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (idx_q == last_idx) begin
                        idx_q <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Results come back in issue order, so the one carrying
                    // the final index is the last thing left in the pipe.
                    if (pipe_valid && (pipe_idx == last_idx)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The result pipe is emptied by reset and by an effective abort so a
    // cancelled command cannot write results afterwards.
    assign pipe_flush = wb_rst_i || abort_now;

    vec_seq_pipe #(
        .DEPTH (ALU_LAT),
        .WIDTH (IDX_W)
    ) u_pipe (
        .clock       (wb_clk_i),
        .flush       (pipe_flush),
        .issue_valid (alu_issue),
        .issue_idx   (alu_idx),
        .res_valid   (pipe_valid),
        .res_idx     (pipe_idx)
    );

    // Output decode from the registered state. Result writes and the done
    // pulse are masked in the abort cycle itself so a cancelled command never
    // reports anything once abort is seen.
    assign cmd_ready      = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign ld_ready       = in_load;
    assign vreg_we        = in_load && ld_valid;
    assign vreg_sel       = (state == ST_LOAD_B);
    assign vreg_idx       = in_load ? idx_q : '0;
    assign alu_issue      = (state == ST_EXEC);
    assign alu_idx        = (state == ST_EXEC) ? idx_q : '0;
    assign alu_op         = op_q;
    assign res_we         = pipe_valid && !abort_now;
    assign res_idx        = pipe_idx;
    assign done           = (state == ST_DONE) && !abort_now;
    assign flag_alu_rst   = (state == ST_ARST);
    assign flag_operand   = vreg_sel;
    assign flag_operation = busy ? op_q : 4'd0;

`ifdef VEC_SEQ_CYCLE_CNT_EN
    logic [31:0] cnt_q;

    // Busy-cycle counter: restarts at zero when a command is taken, counts
    // every non-IDLE cycle, and simply holds while idle so software can read
    // the duration of the last command. Rollover at 2^32 is natural wrap.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign cycle_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_alu_sequencer
// Scoreboard bench for vec_alu_sequencer. The driver works at command level:
// for each command it works out from the command rules alone which operand
// writes, issues, results and how many busy cycles must appear, and queues
// them. An independent monitor samples the DUT on every falling edge and
// pops/compares whenever the DUT presents an event.
// ---------------------------------------------------------------------------
module tb_vec_alu_sequencer;
    import vec_seq_pkg::*;

    localparam int TB_ALU_LAT = 2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic        abort;
    logic        ld_valid;
    logic        ld_ready;
    logic        vreg_we;
    logic        vreg_sel;
    logic [3:0]  vreg_idx;
    logic        alu_issue;
    logic [3:0]  alu_op;
    logic [3:0]  alu_idx;
    logic        res_we;
    logic [3:0]  res_idx;
    logic        busy;
    logic        done;
    logic        flag_alu_rst;
    logic        flag_operand;
    logic [3:0]  flag_operation;
    logic [31:0] cycle_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard state
    logic [4:0] exp_vwe_q[$];
    logic [3:0] exp_issue_q[$];
    logic [3:0] exp_res_q[$];
    int         issue_time_q[$];
    int         exp_done_q[$];
    logic [3:0] cur_op = 4'd0;

    // Monitor-owned event counters
    int cyc       = 0;
    int busy_run  = 0;
    int issue_cnt = 0;
    int write_cnt = 0;
    int done_cnt  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    vec_alu_sequencer #(
        .VLEN    (16),
        .IDX_W   (4),
        .ALU_LAT (TB_ALU_LAT)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_len        (cmd_len),
        .abort          (abort),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .vreg_we        (vreg_we),
        .vreg_sel       (vreg_sel),
        .vreg_idx       (vreg_idx),
        .alu_issue      (alu_issue),
        .alu_op         (alu_op),
        .alu_idx        (alu_idx),
        .res_we         (res_we),
        .res_idx        (res_idx),
        .busy           (busy),
        .done           (done),
        .flag_alu_rst   (flag_alu_rst),
        .flag_operand   (flag_operand),
        .flag_operation (flag_operation),
        .cycle_cnt      (cycle_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Every output in its post-reset / idle-after-abort value
    task automatic checkIdle(input string tag);
        checkOutput({tag, " cmd_ready"},      32'(cmd_ready),      32'd1);
        checkOutput({tag, " busy"},           32'(busy),           32'd0);
        checkOutput({tag, " done"},           32'(done),           32'd0);
        checkOutput({tag, " ld_ready"},       32'(ld_ready),       32'd0);
        checkOutput({tag, " vreg_we"},        32'(vreg_we),        32'd0);
        checkOutput({tag, " vreg_sel"},       32'(vreg_sel),       32'd0);
        checkOutput({tag, " vreg_idx"},       32'(vreg_idx),       32'd0);
        checkOutput({tag, " alu_issue"},      32'(alu_issue),      32'd0);
        checkOutput({tag, " alu_op"},         32'(alu_op),         32'd0);
        checkOutput({tag, " alu_idx"},        32'(alu_idx),        32'd0);
        checkOutput({tag, " res_we"},         32'(res_we),         32'd0);
        checkOutput({tag, " res_idx"},        32'(res_idx),        32'd0);
        checkOutput({tag, " flag_alu_rst"},   32'(flag_alu_rst),   32'd0);
        checkOutput({tag, " flag_operand"},   32'(flag_operand),   32'd0);
        checkOutput({tag, " flag_operation"}, 32'(flag_operation), 32'd0);
        checkOutput({tag, " cycle_cnt"},      cycle_cnt,           32'd0);
    endtask

    task automatic clearScoreboard();
        exp_vwe_q.delete();
        exp_issue_q.delete();
        exp_res_q.delete();
        issue_time_q.delete();
        exp_done_q.delete();
    endtask

    task automatic pushCommand(input int len_eff, input bit with_exec);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < len_eff; i++) begin
                exp_vwe_q.push_back({s[0], 4'(i)});
            end
        end
        if (with_exec) begin
            for (int i = 0; i < len_eff; i++) begin
                exp_issue_q.push_back(4'(i));
                exp_res_q.push_back(4'(i));
            end
        end
    endtask

    // Waits (bounded) for an IDLE falling edge, then offers the command.
    task automatic offerCommand(input logic [3:0] op, input logic [4:0] len);
        int n = 0;
        @(negedge wb_clk_i);
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 64) checkOutput("cmd_ready wait", 32'(cmd_ready), 32'd1);
        cur_op    = op;
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
    endtask

    // One complete command. ld_valid follows a pattern indexed by the cycle
    // count after acceptance (0 = the ALU-reset cycle). The reference model
    // finds how many cycles it takes to see 2*len operand words and adds the
    // fixed costs: reset 1, execute len, drain ALU_LAT, done 1.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] len,
                                 input int gap_at, input int gap_len, input int stall_pct);
        bit pat [256];
        int len_eff, ones, kend, total, base_done, k;
        len_eff = (len > 5'd16) ? 16 : int'(len);
        for (int i = 0; i < 256; i++) begin
            pat[i] = (i >= 160) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        end
        for (int i = gap_at; i < gap_at + gap_len; i++) pat[i] = 1'b0;
        ones = 0;
        kend = 0;
        if (len_eff > 0) begin
            for (int i = 1; i < 256; i++) begin
                if (pat[i]) ones++;
                if (ones == 2 * len_eff) begin
                    kend = i;
                    break;
                end
            end
        end
        total = (len_eff == 0) ? 2 : (1 + kend + len_eff + TB_ALU_LAT + 1);
        pushCommand(len_eff, 1'b1);
        exp_done_q.push_back(total);
        base_done = done_cnt;
        offerCommand(op, len);
        k = 0;
        while (done_cnt == base_done && k < 400) begin
            ld_valid = pat[k % 256];
            @(posedge wb_clk_i);
            #1;
            k++;
        end
        ld_valid = 1'b0;
        checkOutput("done seen", 32'(done_cnt - base_done), 32'd1);
        @(negedge wb_clk_i);
        checkOutput("cmd_ready after done", 32'(cmd_ready), 32'd1);
`ifdef VEC_SEQ_CYCLE_CNT_EN
        checkOutput("cycle_cnt", cycle_cnt, 32'(total));
`else
        checkOutput("cycle_cnt", cycle_cnt, 32'd0);
`endif
    endtask

    // abort in the cycle after the second issue
    task automatic runAbort(input logic [3:0] op);
        int base, n;
        pushCommand(4, 1'b1);
        base = issue_cnt;
        offerCommand(op, 5'd4);
        ld_valid = 1'b1;
        n = 0;
        while (issue_cnt < base + 2 && n < 100) begin
            @(posedge wb_clk_i);
            #1;
            n++;
        end
        checkOutput("issues before abort", 32'(issue_cnt - base), 32'd2);
        abort    = 1'b1;
        ld_valid = 1'b0;
        clearScoreboard();
        @(posedge wb_clk_i);
        #1 abort = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("abort cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("abort busy",      32'(busy),      32'd0);
        checkOutput("abort done",      32'(done),      32'd0);
        checkOutput("abort res_we",    32'(res_we),    32'd0);
        repeat (TB_ALU_LAT + 3) @(negedge wb_clk_i);
    endtask

    // reset pulse after the first operand-B write
    task automatic runResetInLoadB(input logic [3:0] op);
        int base, n;
        pushCommand(3, 1'b0);
        base = write_cnt;
        offerCommand(op, 5'd3);
        ld_valid = 1'b1;
        n = 0;
        while (write_cnt < base + 4 && n < 100) begin
            @(posedge wb_clk_i);
            #1;
            n++;
        end
        checkOutput("writes before reset", 32'(write_cnt - base), 32'd4);
        wb_rst_i = 1'b1;
        clearScoreboard();
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        ld_valid = 1'b0;
        @(negedge wb_clk_i);
        checkIdle("mid reset");
    endtask

    // Monitor: pops the scoreboard on every DUT event. Reset and abort
    // cycles are skipped because the command is being discarded there.
    initial begin : monitor
        logic [4:0] ev;
        logic [3:0] ei;
        int t;
        int ed;
        forever begin
            @(negedge wb_clk_i);
            cyc++;
            busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
            if (wb_rst_i === 1'b0 && abort === 1'b0) begin
                if (vreg_we) begin
                    write_cnt++;
                    if (exp_vwe_q.size() == 0) begin
                        checkOutput("vreg_we spurious", 32'(vreg_we), 32'd0);
                    end else begin
                        ev = exp_vwe_q.pop_front();
                        checkOutput("vreg_sel",     32'(vreg_sel),     32'(ev[4]));
                        checkOutput("vreg_idx",     32'(vreg_idx),     32'(ev[3:0]));
                        checkOutput("flag_operand", 32'(flag_operand), 32'(ev[4]));
                    end
                end
                if (alu_issue) begin
                    issue_cnt++;
                    issue_time_q.push_back(cyc);
                    if (exp_issue_q.size() == 0) begin
                        checkOutput("alu_issue spurious", 32'(alu_issue), 32'd0);
                    end else begin
                        ei = exp_issue_q.pop_front();
                        checkOutput("alu_idx", 32'(alu_idx), 32'(ei));
                        checkOutput("alu_op",  32'(alu_op),  32'(cur_op));
                    end
                end
                if (res_we) begin
                    if (exp_res_q.size() == 0 || issue_time_q.size() == 0) begin
                        checkOutput("res_we spurious", 32'(res_we), 32'd0);
                    end else begin
                        ei = exp_res_q.pop_front();
                        t  = issue_time_q.pop_front();
                        checkOutput("res_idx",     32'(res_idx),  32'(ei));
                        checkOutput("res latency", 32'(cyc - t),  32'(TB_ALU_LAT));
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done_q.size() == 0) begin
                        checkOutput("done spurious", 32'(done), 32'd0);
                    end else begin
                        ed = exp_done_q.pop_front();
                        checkOutput("busy cycles",       32'(busy_run),          32'(ed));
                        checkOutput("pending writes",    32'(exp_vwe_q.size()),  32'd0);
                        checkOutput("pending issues",    32'(exp_issue_q.size()), 32'd0);
                        checkOutput("pending results",   32'(exp_res_q.size()),  32'd0);
                    end
                end
                checkOutput("flag_operation", 32'(flag_operation),
                            (busy === 1'b1) ? 32'(cur_op) : 32'd0);
`ifndef VEC_SEQ_CYCLE_CNT_EN
                checkOutput("cycle_cnt tied", cycle_cnt, 32'd0);
`endif
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_len   = 5'd0;
        abort     = 1'b0;
        ld_valid  = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkIdle("reset");

        $display("[TB] directed: len 4, ld_valid held high");
        applyStimulus(OP_ADD, 5'd4, 0, 0, 0);
        $display("[TB] directed: len 3, 5-cycle gap in operand A");
        applyStimulus(OP_SUB, 5'd3, 2, 5, 0);
        $display("[TB] directed: len 0 and len 20");
        applyStimulus(OP_MUL, 5'd0, 0, 0, 30);
        applyStimulus(OP_AND, 5'd20, 0, 0, 0);
        $display("[TB] directed: abort after second issue");
        runAbort(OP_OR);
        $display("[TB] directed: reset during operand B");
        runResetInLoadB(OP_XOR);
        applyStimulus(OP_XOR, 5'd2, 0, 0, 0);

        $display("[TB] random commands");
        for (int r = 0; r < 24; r++) begin
            applyStimulus(4'($urandom_range(5)), 5'($urandom_range(20)), 0, 0,
                          int'($urandom_range(40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
